branch_resolver: RTL and testbench

Execute-stage branch resolution unit: the write side of the branch predictor. It accepts resolved branches from the execute stage and compares the actual next address against the prediction carried down the pipeline. On a mismatch it issues a redirect and a fetch flush. It also queues table-update writes (set or clear of a predictor entry) toward the predictor through a valid/ready handshake.

---
 rtl/branch_resolver.sv | 155 +++++++++++++++
 tb/tb_branch_resolver.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - execute-stage branch resolution: redirect/flush on mispredict, queued predictor updates.
// Optional BRANCH_STATS_EN adds branch_count and mispredict_count.
module branch_resolver #(
  parameter int UPD_DEPTH    = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [31:0] res_pc,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  input  logic        res_pred,
  input  logic [31:0] res_pred_addr,
  output logic        redirect_valid,
  output logic [31:0] redirect_addr,
  output logic        flush,
  output logic        upd_valid,
  input  logic        upd_ready,
  output logic [3:0]  upd_index,
  output logic [31:0] upd_target,
  output logic        upd_set
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
`endif
);

  localparam int PW = $clog2(UPD_DEPTH);
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int EW = 4 + 32 + 1;
  localparam logic [PW:0]   FULL_CNT   = (PW+1)'(UPD_DEPTH);
  localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          res_ready_q, res_ready_d;
  logic          redirect_valid_q, redirect_valid_d;
  logic [31:0]   redirect_addr_q, redirect_addr_d;
  logic          flush_q, flush_d;
  logic [EW-1:0] mem_q [UPD_DEPTH];
  logic [EW-1:0] mem_d [UPD_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  logic          accept, mispredict, push, pop;
  logic [31:0]   actual_next;

  always_comb begin
    accept      = res_valid && res_ready_q;
    actual_next = res_taken ? res_target : res_pc + 32'd4;
    // Only the address matters: a stale prediction bit with a matching address is harmless.
    mispredict  = (actual_next != res_pred_addr);
    push        = accept && (res_taken || res_pred);
    pop         = (count_q != '0) && upd_ready;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {res_pc[3:0], (res_taken ? res_target : 32'd0), res_taken};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (accept && mispredict) begin
          state_d = FLUSH;
          fcnt_d  = FLUSH_INIT;
        end
      end
      FLUSH: begin
        if (fcnt_q == '0) state_d = IDLE;
        else              fcnt_d  = fcnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    redirect_valid_d = accept && mispredict;
    redirect_addr_d  = redirect_valid_d ? actual_next : redirect_addr_q;
    flush_d          = (state_d == FLUSH);
    // Ready is computed from next state so it is a plain flop; a full queue blocks even while popping.
    res_ready_d      = (state_d == IDLE) && (count_d != FULL_CNT);
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;

  always_comb begin
    branch_count_d     = branch_count_q + {31'd0, accept};
    mispredict_count_d = mispredict_count_q + {31'd0, accept && mispredict};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      fcnt_q           <= '0;
      res_ready_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_addr_q  <= '0;
      flush_q          <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      for (int i = 0; i < UPD_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q          <= state_d;
      fcnt_q           <= fcnt_d;
      res_ready_q      <= res_ready_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_addr_q  <= redirect_addr_d;
      flush_q          <= flush_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      mem_q            <= mem_d;
    end
  end

  assign res_ready      = res_ready_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_addr  = redirect_addr_q;
  assign flush          = flush_q;
  assign upd_valid      = (count_q != '0);
  assign {upd_index, upd_target, upd_set} = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - directed self-checking bench for branch_resolver with an update scoreboard.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid, res_ready;
  logic [31:0] res_pc, res_target, res_pred_addr;
  logic        res_taken, res_pred;
  logic        redirect_valid, flush, upd_valid, upd_ready, upd_set;
  logic [31:0] redirect_addr, upd_target;
  logic [3:0]  upd_index;
`ifdef BRANCH_STATS_EN
  logic [31:0] branch_count, mispredict_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [36:0] sbq[$];
  int exp_bc = 0;
  int exp_mc = 0;

  always #5 clk = ~clk;

  branch_resolver #(.UPD_DEPTH(4), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc),
    .res_taken(res_taken), .res_target(res_target), .res_pred(res_pred),
    .res_pred_addr(res_pred_addr),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .flush(flush),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index),
    .upd_target(upd_target), .upd_set(upd_set)
`ifdef BRANCH_STATS_EN
    , .branch_count(branch_count), .mispredict_count(mispredict_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one resolved branch for one edge; the model decides redirect and update outcome.
  task automatic send(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                      input logic pred, input logic [31:0] paddr, output logic mp);
    logic [31:0] nxt;
    chk("res_ready_before_send", {31'd0, res_ready}, 32'd1);
    nxt = taken ? tgt : pc + 32'd4;
    mp  = (nxt != paddr);
    if (taken)     sbq.push_back({pc[3:0], tgt, 1'b1});
    else if (pred) sbq.push_back({pc[3:0], 32'd0, 1'b0});
    exp_bc++;
    if (mp) exp_mc++;
    res_valid = 1'b1; res_pc = pc; res_taken = taken; res_target = tgt;
    res_pred = pred; res_pred_addr = paddr;
    tick();
    res_valid = 1'b0;
  endtask

  // Every handshaken update must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && upd_valid && upd_ready) begin
      chk("upd_expected", {31'd0, sbq.size() != 0}, 32'd1);
      if (sbq.size() != 0) begin
        logic [36:0] e;
        e = sbq.pop_front();
        chk("upd_index", {28'd0, upd_index}, {28'd0, e[36:33]});
        chk("upd_target", upd_target, e[32:1]);
        chk("upd_set", {31'd0, upd_set}, {31'd0, e[0]});
      end
    end
  end

  initial begin
    logic mp;
    rst = 1'b1; res_valid = 1'b0; res_pc = '0; res_taken = 1'b0; res_target = '0;
    res_pred = 1'b0; res_pred_addr = '0; upd_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_ready", {31'd0, res_ready}, 32'd0);
    chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("rst_redirect_addr", redirect_addr, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_upd_valid", {31'd0, upd_valid}, 32'd0);
    chk("rst_upd_target", upd_target, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", {31'd0, res_ready}, 32'd1);
    chk("post_rst_upd_valid", {31'd0, upd_valid}, 32'd0);

    // correctly predicted taken branch
    send(32'h100, 1'b1, 32'h200, 1'b1, 32'h200, mp);
    chk("t1_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("t1_flush", {31'd0, flush}, 32'd0);
    chk("t1_upd_valid", {31'd0, upd_valid}, 32'd1);
    tick();

    // predicted taken, actually not taken: mispredict
    send(32'h104, 1'b0, 32'h0, 1'b1, 32'h300, mp);
    chk("t2_redirect", {31'd0, redirect_valid}, 32'd1);
    chk("t2_redirect_addr", redirect_addr, 32'h108);
    chk("t2_flush_c1", {31'd0, flush}, 32'd1);
    chk("t2_ready_c1", {31'd0, res_ready}, 32'd0);
    tick();
    chk("t2_redirect_pulse", {31'd0, redirect_valid}, 32'd0);
    chk("t2_redirect_hold", redirect_addr, 32'h108);
    chk("t2_flush_c2", {31'd0, flush}, 32'd1);
    chk("t2_ready_c2", {31'd0, res_ready}, 32'd0);
    tick();
    chk("t2_flush_end", {31'd0, flush}, 32'd0);
    chk("t2_ready_back", {31'd0, res_ready}, 32'd1);
    chk("t2_queue_drained", sbq.size(), 32'd0);

    // prediction bit disagrees but address matches: no redirect, clear update
    send(32'h120, 1'b0, 32'h0, 1'b1, 32'h124, mp);
    chk("t2b_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("t2b_flush", {31'd0, flush}, 32'd0);
    tick();

    // fill the queue with back-to-back branches while the predictor stalls
    upd_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(32'h110 + 32'(i*4), 1'b1, 32'h400 + 32'(i*16), 1'b0, 32'h400 + 32'(i*16), mp);
    chk("t3_full_ready", {31'd0, res_ready}, 32'd0);
    tick();
    chk("t3_full_hold", {31'd0, res_ready}, 32'd0);
    chk("t3_upd_valid", {31'd0, upd_valid}, 32'd1);
    upd_ready = 1'b1;
    repeat (3) tick();
    chk("t3_drain_mid", {31'd0, upd_valid}, 32'd1);
    chk("t3_ready_reopen", {31'd0, res_ready}, 32'd1);
    tick();
    chk("t3_drain_done", {31'd0, upd_valid}, 32'd0);
    chk("t3_sb_empty", sbq.size(), 32'd0);

    // PC wrap, correct not-taken prediction: nothing enqueued
    send(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, mp);
    chk("t4_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("t4_flush", {31'd0, flush}, 32'd0);
    chk("t4_upd_valid", {31'd0, upd_valid}, 32'd0);
`ifdef BRANCH_STATS_EN
    chk("t4_branch_count", branch_count, 32'(exp_bc));
    chk("t4_mispredict_count", mispredict_count, 32'(exp_mc));
`endif
    tick();

    // reset during the first flush cycle with a pending update
    upd_ready = 1'b0;
    send(32'h200, 1'b1, 32'h500, 1'b0, 32'h204, mp);
    chk("t5_flush_c1", {31'd0, flush}, 32'd1);
    chk("t5_upd_pending", {31'd0, upd_valid}, 32'd1);
    rst = 1'b1;
    sbq.delete();
    tick();
    chk("t5_flush_cleared", {31'd0, flush}, 32'd0);
    chk("t5_queue_empty", {31'd0, upd_valid}, 32'd0);
    chk("t5_redirect_cleared", {31'd0, redirect_valid}, 32'd0);
`ifdef BRANCH_STATS_EN
    chk("t5_branch_count", branch_count, 32'd0);
    chk("t5_mispredict_count", mispredict_count, 32'd0);
`endif
    rst = 1'b0;
    upd_ready = 1'b1;
    tick();
    chk("t5_ready_after", {31'd0, res_ready}, 32'd1);
    chk("t5_flush_after", {31'd0, flush}, 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
